// File: rtl/pc_sequencer_if.sv
// ----------------------------------------------------------------------------
// pc_sequencer_if
// Groups the control-unit / ALU / memory-side signals of the PC sequencer.
//   master : driven by the control unit side (BUSYWAIT, JUMP, BRANCH_EQ,
//            BRANCH_NE, ZERO, OFFSET8); observes PC, PC_PLUS4, STALLED,
//            REDIRECT (and TAKEN_CNT when PC_TRACE_EN is defined).
//   slave  : the pc_sequencer itself (mirror directions).
// Optional feature macro: PC_TRACE_EN adds the TAKEN_CNT signal (width CNT_W).
// ----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int CNT_W = 16
);
    logic                    BUSYWAIT;
    logic                    JUMP;
    logic                    BRANCH_EQ;
    logic                    BRANCH_NE;
    logic                    ZERO;
    logic signed [7:0]       OFFSET8;
    logic        [31:0]      PC;
    logic        [31:0]      PC_PLUS4;
    logic                    STALLED;
    logic                    REDIRECT;
`ifdef PC_TRACE_EN
    logic        [CNT_W-1:0] TAKEN_CNT;
`endif

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pc_sequencer_if: CNT_W must be at least 1");
    end

`ifdef PC_TRACE_EN
    modport master (
        output BUSYWAIT, JUMP, BRANCH_EQ, BRANCH_NE, ZERO, OFFSET8,
        input  PC, PC_PLUS4, STALLED, REDIRECT, TAKEN_CNT
    );
    modport slave (
        input  BUSYWAIT, JUMP, BRANCH_EQ, BRANCH_NE, ZERO, OFFSET8,
        output PC, PC_PLUS4, STALLED, REDIRECT, TAKEN_CNT
    );
`else
    modport master (
        output BUSYWAIT, JUMP, BRANCH_EQ, BRANCH_NE, ZERO, OFFSET8,
        input  PC, PC_PLUS4, STALLED, REDIRECT
    );
    modport slave (
        input  BUSYWAIT, JUMP, BRANCH_EQ, BRANCH_NE, ZERO, OFFSET8,
        output PC, PC_PLUS4, STALLED, REDIRECT
    );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Owns the program counter of the 8-bit CPU. Every cycle the PC either steps
// by PC_STEP or loads PC+PC_STEP+sext(OFFSET8<<2) when a jump/branch is taken.
// A memory stall (BUSYWAIT) freezes the PC; the branch decision seen on the
// cycle the stall began is captured and applied when the stall releases.
//
// Ports
//   CLK    in  : clock, all state changes on the rising edge
//   RESET  in  : synchronous, active-high reset (wins over every other input)
//   bus    slave modport of pc_sequencer_if:
//     BUSYWAIT, JUMP, BRANCH_EQ, BRANCH_NE, ZERO, OFFSET8 (inputs)
//     PC (registered), PC_PLUS4 (combinational), STALLED, REDIRECT,
//     TAKEN_CNT (PC_TRACE_EN only)
//
// Optional feature macro: PC_TRACE_EN -- saturating count of REDIRECT pulses.
// ----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter int          CNT_W    = 16
) (
    input  logic           CLK,
    input  logic           RESET,
    pc_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic        [31:0] pc_q, pc_d;
    logic               pend_q, pend_d;
    logic        [31:0] pend_tgt_q, pend_tgt_d;
    logic               redirect_q, redirect_d;

    logic        [31:0] pc_plus4;
    logic signed [31:0] offset_ext;
    logic        [31:0] target;
    logic               taken;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pc_sequencer: CNT_W must be at least 1");
    end

    // OFFSET8 counts instruction words; scale to bytes with sign extension.
    assign offset_ext = {{22{bus.OFFSET8[7]}}, bus.OFFSET8, 2'b00};
    assign pc_plus4   = pc_q + PC_STEP;
    assign target     = pc_plus4 + $unsigned(offset_ext);
    assign taken      = bus.JUMP
                      | (bus.BRANCH_EQ &  bus.ZERO)
                      | (bus.BRANCH_NE & ~bus.ZERO);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        redirect_d = 1'b0;

        unique case (state_q)
            S_BOOT: begin
                // First fetch happens at RESET_PC; PC is held for this cycle.
                state_d = S_RUN;
            end
            S_RUN: begin
                if (bus.BUSYWAIT) begin
                    pend_d     = taken;
                    pend_tgt_d = target;
                    state_d    = S_STALL;
                end else begin
                    pc_d       = taken ? target : pc_plus4;
                    redirect_d = taken;
                end
            end
            S_STALL: begin
                // Control inputs are ignored here; the decision is already latched.
                if (!bus.BUSYWAIT) begin
                    pc_d       = pend_q ? pend_tgt_q : pc_plus4;
                    redirect_d = pend_q;
                    pend_d     = 1'b0;
                    state_d    = S_RUN;
                end
            end
            default: begin
                state_d    = S_BOOT;
                pc_d       = RESET_PC;
                pend_d     = 1'b0;
                pend_tgt_d = 32'h0000_0000;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'h0000_0000;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            redirect_q <= redirect_d;
        end
    end

    assign bus.PC       = pc_q;
    assign bus.PC_PLUS4 = pc_plus4;
    assign bus.STALLED  = (state_q == S_STALL);
    assign bus.REDIRECT = redirect_q;

`ifdef PC_TRACE_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Counts on the same edge that raises REDIRECT, so both are visible together.
    always_comb begin
        cnt_d = cnt_q;
        if (redirect_d) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.TAKEN_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

`ifdef PC_TRACE_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic clk;
    logic rst;

    pc_sequencer_if #(.CNT_W(CNT_W)) bus ();

    pc_sequencer #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd4),
        .CNT_W    (CNT_W)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] pc;
        logic        red;
        logic        st;
        logic [CNT_W-1:0] cnt;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation that is due after the current edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.due != cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL %s.stale due=%0d now=%0d", e.nm, e.due, cyc);
            end else begin
                n_cmp++;
                if (bus.PC !== e.pc) begin
                    n_bad++;
                    $display("FAIL %s.pc actual=%h required=%h", e.nm, bus.PC, e.pc);
                end
                n_cmp++;
                if (bus.PC_PLUS4 !== e.pc + 32'd4) begin
                    n_bad++;
                    $display("FAIL %s.pc_plus4 actual=%h required=%h", e.nm, bus.PC_PLUS4, e.pc + 32'd4);
                end
                n_cmp++;
                if (bus.REDIRECT !== e.red) begin
                    n_bad++;
                    $display("FAIL %s.redirect actual=%b required=%b", e.nm, bus.REDIRECT, e.red);
                end
                n_cmp++;
                if (bus.STALLED !== e.st) begin
                    n_bad++;
                    $display("FAIL %s.stalled actual=%b required=%b", e.nm, bus.STALLED, e.st);
                end
`ifdef PC_TRACE_EN
                n_cmp++;
                if (bus.TAKEN_CNT !== e.cnt) begin
                    n_bad++;
                    $display("FAIL %s.taken_cnt actual=%0d required=%0d", e.nm, bus.TAKEN_CNT, e.cnt);
                end
`endif
            end
        end
    end

    // Drives one cycle of inputs and records the state expected after the next edge.
    task automatic step(input logic r, input logic bw, input logic j,
                        input logic beq, input logic bne, input logic z,
                        input logic [7:0] off, input logic [31:0] epc,
                        input logic ered, input logic est, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        bus.BUSYWAIT  = bw;
        bus.JUMP      = j;
        bus.BRANCH_EQ = beq;
        bus.BRANCH_NE = bne;
        bus.ZERO      = z;
        bus.OFFSET8   = off;
        if (r) exp_cnt = '0;
        else if (ered && !(&exp_cnt)) exp_cnt = exp_cnt + 1'b1;
        e.due = cyc + 1;
        e.pc  = epc;
        e.red = ered;
        e.st  = est;
        e.cnt = exp_cnt;
        e.nm  = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.BUSYWAIT  = 1'b0;
        bus.JUMP      = 1'b0;
        bus.BRANCH_EQ = 1'b0;
        bus.BRANCH_NE = 1'b0;
        bus.ZERO      = 1'b0;
        bus.OFFSET8   = 8'h00;

        //   rst bw j beq bne z off     pc            red st
        step(1, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0000, 0, 0, "rst1");
        step(1, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0000, 0, 0, "rst2");
        step(0, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0000, 0, 0, "boot");
        step(0, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0004, 0, 0, "seq4");
        step(0, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0008, 0, 0, "seq8");
        step(0, 0, 0, 0, 0, 0, 8'h00, 32'h0000_000C, 0, 0, "seqC");
        step(0, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0010, 0, 0, "seq10");
        step(0, 0, 1, 0, 0, 0, 8'h02, 32'h0000_001C, 1, 0, "jump_fwd");
        step(0, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0020, 0, 0, "after_jump");
        step(0, 0, 0, 1, 0, 0, 8'hFE, 32'h0000_0024, 0, 0, "beq_not_taken");
        step(0, 0, 1, 0, 0, 0, 8'hFE, 32'h0000_0020, 1, 0, "jump_back");
        step(0, 0, 0, 0, 1, 0, 8'hFE, 32'h0000_001C, 1, 0, "bne_taken");
        step(0, 0, 0, 1, 0, 1, 8'h00, 32'h0000_0020, 1, 0, "beq_taken_off0");
        step(0, 0, 1, 0, 1, 1, 8'h03, 32'h0000_0030, 1, 0, "jump_and_bne");
        step(0, 0, 0, 0, 1, 1, 8'h05, 32'h0000_0034, 0, 0, "bne_not_taken");
        step(0, 0, 1, 0, 0, 0, 8'h02, 32'h0000_0040, 1, 0, "jump_to_40");
        // stall with a taken BNE; inputs change while stalled
        step(0, 1, 0, 0, 1, 0, 8'h01, 32'h0000_0040, 0, 1, "stall1");
        step(0, 1, 1, 0, 0, 0, 8'h7F, 32'h0000_0040, 0, 1, "stall2");
        step(0, 1, 0, 1, 0, 1, 8'h80, 32'h0000_0040, 0, 1, "stall3");
        step(0, 0, 0, 0, 0, 0, 8'h10, 32'h0000_0048, 1, 0, "stall_release");
        step(0, 0, 0, 0, 0, 0, 8'h00, 32'h0000_004C, 0, 0, "after_release");
        // stall with nothing pending; a jump on the release cycle is ignored
        step(0, 1, 0, 0, 0, 0, 8'h00, 32'h0000_004C, 0, 1, "stall_np");
        step(0, 0, 1, 0, 0, 0, 8'h40, 32'h0000_0050, 0, 0, "release_np");
        // reset on the second stall cycle with a pending jump
        step(0, 1, 1, 0, 0, 0, 8'h04, 32'h0000_0050, 0, 1, "stall_jmp");
        step(1, 0, 1, 0, 0, 0, 8'h04, 32'h0000_0000, 0, 0, "rst_mid_stall");
        step(0, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0000, 0, 0, "boot2");
        // wrap-around
        step(0, 0, 1, 0, 0, 0, 8'hFE, 32'hFFFF_FFFC, 1, 0, "jump_neg");
        step(0, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0000, 0, 0, "wrap");
        step(0, 0, 0, 0, 0, 0, 8'h00, 32'h0000_0004, 0, 0, "post_wrap");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
